// File: rtl/bcd_count_sequencer_if.sv
// Load channel of the BCD count sequencer: BCD start value offered over a
// valid/ready handshake, with a one-cycle reject pulse for non-BCD values.
interface bcd_count_sequencer_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] load_value;
  logic                load_valid;
  logic                load_ready;
  logic                load_err;

  modport master (output load_value, output load_valid,
                  input  load_ready, input  load_err);
  modport slave  (input  load_value, input  load_valid,
                  output load_ready, output load_err);
endinterface

// File: rtl/bcd_count_sequencer.sv
// BCD count sequencer: owns DIGITS chained BCD digit registers, loads a start
// value in IDLE, then counts up or down at one step per PRESCALE clocks until
// the terminal value (all 9s up, all 0s down), pulsing done for one cycle.
module bcd_count_sequencer #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_count_sequencer_if.slave   ld,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   stop,
  output logic [4*DIGITS-1:0]    count,
  output logic                   busy,
  output logic                   done
);
  localparam int              W       = 4*DIGITS;
  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE-1);
  localparam logic [W-1:0]    ALL9    = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [PW-1:0]  psc_q, psc_d;
  logic           mode_q, mode_d;
  logic           err_q, err_d;

  logic [W-1:0]   up_val, dn_val, step_val, step_term;
  logic           load_ok, cy, bw;
  logic [3:0]     dg, lvd;

  // Ripple BCD increment/decrement of the digit chain and load-value check
  always_comb begin
    up_val  = '0;
    dn_val  = '0;
    load_ok = 1'b1;
    cy      = 1'b1;
    bw      = 1'b1;
    dg      = '0;
    lvd     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dg  = count_q[4*i +: 4];
      lvd = ld.load_value[4*i +: 4];
      if (lvd > 4'd9) load_ok = 1'b0;
      // carry ripples only through digits at 9
      if (cy) begin
        if (dg == 4'd9) up_val[4*i +: 4] = 4'd0;
        else begin
          up_val[4*i +: 4] = dg + 4'd1;
          cy = 1'b0;
        end
      end else begin
        up_val[4*i +: 4] = dg;
      end
      // borrow ripples only through digits at 0
      if (bw) begin
        if (dg == 4'd0) dn_val[4*i +: 4] = 4'd9;
        else begin
          dn_val[4*i +: 4] = dg - 4'd1;
          bw = 1'b0;
        end
      end else begin
        dn_val[4*i +: 4] = dg;
      end
    end
    step_val  = mode_q ? dn_val : up_val;
    step_term = mode_q ? '0 : ALL9;
  end

  // Sequencer next-state: load/start in IDLE, prescaled stepping in RUN
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld.load_valid) begin
          // load wins over a simultaneous start
          if (load_ok) count_d = ld.load_value;
          else         err_d   = 1'b1;
        end else if (start && !stop) begin
          mode_d  = mode;
          psc_d   = '0;
          state_d = (count_q == (mode ? '0 : ALL9)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (psc_q == PS_LAST) begin
          psc_d   = '0;
          count_d = step_val;
          if (step_val == step_term) state_d = DONE;
        end else begin
          psc_d = psc_q + PW'(1);
        end
      end
      PAUSE: begin
        // prescaler phase is held so resuming loses no partial period
        if (start && !stop) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign ld.load_ready = (state_q == IDLE);
  assign ld.load_err   = err_q;
  assign count         = count_q;
  assign busy          = (state_q == RUN) || (state_q == PAUSE);
  assign done          = (state_q == DONE);
endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer: two instances (PRESCALE 1 and 3) checked
// every cycle against a decimal-arithmetic reference model.
module tb_bcd_count_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  md, st, sp;
  logic [15:0] cnt0, cnt1;
  logic        busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_count_sequencer_if #(.DIGITS(4)) if1 ();
  bcd_count_sequencer_if #(.DIGITS(4)) if3 ();

  bcd_count_sequencer #(.DIGITS(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .ld(if1.slave), .mode(md[0]), .start(st[0]),
    .stop(sp[0]), .count(cnt0), .busy(busy0), .done(done0));

  bcd_count_sequencer #(.DIGITS(4), .PRESCALE(3)) u_p3 (
    .clk(clk), .reset(reset), .ld(if3.slave), .mode(md[1]), .start(st[1]),
    .stop(sp[1]), .count(cnt1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  // reference model: decimal value plus run/pause/done flags
  int m_val[2], m_ph[2];
  bit m_run[2], m_pau[2], m_done[2], m_err[2], m_dn[2];
  int PS[2] = '{1, 3};

  function automatic int from_bcd(logic [15:0] v);
    int n = 0;
    for (int i = 3; i >= 0; i--) n = n*10 + int'(v[4*i +: 4]);
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int term(bit dn);
    return dn ? 0 : 9999;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_val[d] = 0; m_ph[d] = 0; m_run[d] = 0; m_pau[d] = 0;
      m_done[d] = 0; m_err[d] = 0; m_dn[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [15:0] lv, input bit lval,
                            input bit mo, input bit s, input bit p);
    m_err[d] = 0;
    if (m_done[d]) begin
      m_done[d] = 0;
    end else if (m_run[d]) begin
      if (p) begin
        m_run[d] = 0; m_pau[d] = 1;
      end else if (m_ph[d] == PS[d]-1) begin
        m_ph[d] = 0;
        m_val[d] += m_dn[d] ? -1 : 1;
        if (m_val[d] == term(m_dn[d])) begin m_run[d] = 0; m_done[d] = 1; end
      end else begin
        m_ph[d]++;
      end
    end else if (m_pau[d]) begin
      if (s && !p) begin m_pau[d] = 0; m_run[d] = 1; end
    end else begin
      if (lval) begin
        if (bcd_ok(lv)) m_val[d] = from_bcd(lv);
        else            m_err[d] = 1;
      end else if (s && !p) begin
        m_dn[d] = mo; m_ph[d] = 0;
        if (m_val[d] == term(mo)) m_done[d] = 1;
        else                      m_run[d]  = 1;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [15:0] c, input logic b,
                           input logic dn, input logic rdy, input logic er);
    string p = (d == 0) ? "p1" : "p3";
    chk({p, ".count"},      32'(c),   32'(to_bcd(m_val[d])));
    chk({p, ".busy"},       32'(b),   32'(m_run[d] | m_pau[d]));
    chk({p, ".done"},       32'(dn),  32'(m_done[d]));
    chk({p, ".load_ready"}, 32'(rdy), 32'(!(m_run[d] | m_pau[d] | m_done[d])));
    chk({p, ".load_err"},   32'(er),  32'(m_err[d]));
  endtask

  task automatic check_all();
    check_dut(0, cnt0, busy0, done0, if1.load_ready, if1.load_err);
    check_dut(1, cnt1, busy1, done1, if3.load_ready, if3.load_err);
  endtask

  // one clock: drive DUT d, idle the other, advance model, compare after edge
  task automatic cyc(input int d, input logic [15:0] lv, input bit lval,
                     input bit mo, input bit s, input bit p);
    @(negedge clk);
    if1.load_value = (d == 0) ? lv : 16'h0;
    if1.load_valid = (d == 0) ? lval : 1'b0;
    if3.load_value = (d == 1) ? lv : 16'h0;
    if3.load_valid = (d == 1) ? lval : 1'b0;
    md = '0; st = '0; sp = '0;
    md[d] = mo; st[d] = s; sp[d] = p;
    for (int k = 0; k < 2; k++)
      if (k == d) model_step(k, lv, lval, mo, s, p);
      else        model_step(k, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to_idle(input int d, input int max);
    int i = 0;
    while ((m_run[d] || m_pau[d] || m_done[d]) && i < max) begin
      cyc(d, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      i++;
    end
    chk("run_to_idle.bound", 32'(i < max), 32'd1);
  endtask

  // asynchronous reset asserted between edges, checked before any clock edge
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    if1.load_value = '0; if1.load_valid = 1'b0;
    if3.load_value = '0; if3.load_valid = 1'b0;
    md = '0; st = '0; sp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // down count 0012 -> 0000 at PRESCALE 1
    cyc(0, 16'h0012, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 1, 1, 0);
    run_to_idle(0, 100);
    chk("t1.final", 32'(cnt0), 32'h0000);

    // up count 0998 through triple carry to 9999
    cyc(0, 16'h0998, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("t2.0999", 32'(cnt0), 32'h0999);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("t2.1000", 32'(cnt0), 32'h1000);
    run_to_idle(0, 10000);
    chk("t2.final", 32'(cnt0), 32'h9999);

    // non-BCD load rejected; load wins over start
    cyc(0, 16'h00A5, 1, 0, 0, 0);
    chk("t3.err", 32'(if1.load_err), 32'd1);
    cyc(0, 16'h0005, 1, 0, 1, 0);
    chk("t3.load_prio", 32'(busy0), 32'd0);

    // PRESCALE 3 pause/resume keeps phase
    cyc(1, 16'h0000, 1, 0, 0, 0);
    cyc(1, 16'h0000, 0, 0, 1, 0);
    idle(1, 6);
    cyc(1, 16'h0000, 0, 0, 0, 1);
    chk("t4.hold", 32'(cnt1), 32'h0002);
    idle(1, 10);
    chk("t4.paused", 32'(cnt1), 32'h0002);
    cyc(1, 16'h0000, 0, 1, 1, 0);
    idle(1, 9);

    // start+stop together: IDLE stays, RUN pauses
    cyc(0, 16'h0040, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 1, 1);
    chk("t5.idle", 32'(busy0), 32'd0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    cyc(0, 16'h0000, 0, 0, 1, 1);
    idle(0, 2);

    // async reset mid-run at 0057
    async_reset();
    cyc(0, 16'h0050, 1, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    idle(0, 7);
    chk("t6.pre", 32'(cnt0), 32'h0057);
    async_reset();

    // randomized traffic against the model
    for (int it = 0; it < 4000; it++) begin
      int d = int'($urandom_range(1, 0));
      int r = int'($urandom_range(99, 0));
      bit mo = 1'($urandom);
      logic [15:0] lv;
      case ($urandom_range(3, 0))
        0:       lv = to_bcd(int'($urandom_range(30, 0)));
        1:       lv = to_bcd(int'($urandom_range(9999, 9970)));
        2:       lv = 16'($urandom);
        default: lv = to_bcd(int'($urandom_range(9999, 0)));
      endcase
      if      (r < 10) cyc(d, lv, 1, mo, 1'($urandom), 0);
      else if (r < 22) cyc(d, lv, 1'($urandom_range(9, 0) == 0), mo, 1, 0);
      else if (r < 28) cyc(d, lv, 0, mo, 0, 1);
      else if (r < 31) cyc(d, lv, 0, mo, 1, 1);
      else if (r < 32) async_reset();
      else             cyc(d, lv, 1'($urandom_range(9, 0) == 0), mo, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
